sal_cmd_sched: RTL

Per-channel DRAM command scheduler. It sits between the per-bank controllers and the DRAM command issue stage. Each cycle it picks at most one bank's ACT/RD/WR/PRE/REF request and returns a same-cycle grant to that bank. It enforces the inter-bank timing constraints no single bank can see (tRRD, tCCD, tWTR, optionally tFAW) and registers the chosen command toward the PHY.

---
 rtl/sal_cmd_sched_if.sv | 50 +++++
 rtl/sal_cmd_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sal_cmd_sched_if.sv
// Bank-side bus of the channel command scheduler: per-bank requests,
// addresses and grants, the shared timing values, and the registered
// command toward the PHY. The scheduler uses the slave view.
interface sal_cmd_sched_if #(
    parameter int NUM_BANKS = 4,
    parameter int RA_WIDTH  = 16,
    parameter int CA_WIDTH  = 10,
    parameter int TW        = 4
);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int AW = (RA_WIDTH > CA_WIDTH) ? RA_WIDTH : CA_WIDTH;

    logic [NUM_BANKS-1:0]          act_req_i;
    logic [NUM_BANKS-1:0]          rd_req_i;
    logic [NUM_BANKS-1:0]          wr_req_i;
    logic [NUM_BANKS-1:0]          pre_req_i;
    logic [NUM_BANKS-1:0]          ref_req_i;
    logic [NUM_BANKS*RA_WIDTH-1:0] ra_i;
    logic [NUM_BANKS*CA_WIDTH-1:0] ca_i;

    logic [NUM_BANKS-1:0]          act_gnt_o;
    logic [NUM_BANKS-1:0]          rd_gnt_o;
    logic [NUM_BANKS-1:0]          wr_gnt_o;
    logic [NUM_BANKS-1:0]          pre_gnt_o;
    logic [NUM_BANKS-1:0]          ref_gnt_o;

    logic [TW-1:0]                 t_rrd_m1;
    logic [TW-1:0]                 t_ccd_m1;
    logic [TW-1:0]                 t_wtr_m1;
    logic [TW-1:0]                 t_faw_m1;

    logic                          cmd_valid_o;
    logic [2:0]                    cmd_o;
    logic [BW-1:0]                 bank_o;
    logic [AW-1:0]                 addr_o;

    modport master (
        output act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i, ra_i, ca_i,
        output t_rrd_m1, t_ccd_m1, t_wtr_m1, t_faw_m1,
        input  act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o,
        input  cmd_valid_o, cmd_o, bank_o, addr_o
    );

    modport slave (
        input  act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i, ra_i, ca_i,
        input  t_rrd_m1, t_ccd_m1, t_wtr_m1, t_faw_m1,
        output act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o,
        output cmd_valid_o, cmd_o, bank_o, addr_o
    );
endinterface

// File: rtl/sal_cmd_sched.sv
// sal_cmd_sched: per-channel DRAM command scheduler.
// Picks at most one bank command per cycle (REF > PRE > ACT > RD/WR, round
// robin inside a class), grants it combinationally and registers it toward
// the PHY. Enforces tRRD, tCCD and tWTR across banks.
// Optional feature: define SAL_SCHED_FAW_EN to compile in a 4-entry tFAW
// window; without it t_faw_m1 is ignored.
module sal_cmd_sched #(
    parameter int NUM_BANKS = 4,
    parameter int RA_WIDTH  = 16,
    parameter int CA_WIDTH  = 10,
    parameter int TW        = 4
) (
    input logic            clk,
    input logic            rst,
    sal_cmd_sched_if.slave bus
);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int AW = (RA_WIDTH > CA_WIDTH) ? RA_WIDTH : CA_WIDTH;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_t;

    logic [BW-1:0]        rr_ptr;
    logic [TW-1:0]        rrd_cnt;
    logic [TW-1:0]        ccd_cnt;
    logic [TW-1:0]        wtr_cnt;

    logic                 faw_ok;
    logic                 act_ok;
    logic                 rd_ok;
    logic                 wr_ok;
    logic [NUM_BANKS-1:0] act_v;
    logic [NUM_BANKS-1:0] rd_v;
    logic [NUM_BANKS-1:0] wr_v;
    logic [NUM_BANKS-1:0] col_v;

    logic [NUM_BANKS-1:0] cls_vec;
    cmd_t                 cls_cmd;
    logic                 gnt_any;
    logic [BW-1:0]        gnt_bank;
    cmd_t                 gnt_cmd;
    logic [NUM_BANKS-1:0] gnt_onehot;
    logic                 gnt_act;
    logic                 gnt_col;
    logic                 gnt_wr;
    logic [AW-1:0]        addr_d;

    logic                 cmd_valid_q;
    cmd_t                 cmd_q;
    logic [BW-1:0]        bank_q;
    logic [AW-1:0]        addr_q;

    // Per-class eligibility from the shared timing counters.
    assign act_ok = (rrd_cnt == '0) && faw_ok;
    assign rd_ok  = (ccd_cnt == '0) && (wtr_cnt == '0);
    assign wr_ok  = (ccd_cnt == '0);

    assign act_v = bus.act_req_i & {NUM_BANKS{act_ok}};
    assign rd_v  = bus.rd_req_i  & {NUM_BANKS{rd_ok}};
    assign wr_v  = bus.wr_req_i  & {NUM_BANKS{wr_ok}};
    assign col_v = rd_v | wr_v;

    // Pick the highest class with an eligible bank, then round robin from rr_ptr.
    always_comb begin
        cls_vec = '0;
        cls_cmd = CMD_NOP;
        if (|bus.ref_req_i) begin
            cls_vec = bus.ref_req_i;
            cls_cmd = CMD_REF;
        end else if (|bus.pre_req_i) begin
            cls_vec = bus.pre_req_i;
            cls_cmd = CMD_PRE;
        end else if (|act_v) begin
            cls_vec = act_v;
            cls_cmd = CMD_ACT;
        end else if (|col_v) begin
            cls_vec = col_v;
            cls_cmd = CMD_RD;
        end

        gnt_any  = 1'b0;
        gnt_bank = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (!gnt_any && cls_vec[BW'((int'(rr_ptr) + i) % NUM_BANKS)]) begin
                gnt_any  = 1'b1;
                gnt_bank = BW'((int'(rr_ptr) + i) % NUM_BANKS);
            end
        end
        // Grants are forced low for as long as reset is held.
        if (rst) begin
            gnt_any = 1'b0;
        end

        gnt_cmd = CMD_NOP;
        if (gnt_any) begin
            gnt_cmd = cls_cmd;
            // A column winner issues RD when its read is eligible, else its WR.
            if (cls_cmd == CMD_RD && !rd_v[gnt_bank]) begin
                gnt_cmd = CMD_WR;
            end
        end
    end

    assign gnt_onehot = gnt_any ? (NUM_BANKS'(1) << gnt_bank) : '0;
    assign gnt_act    = (gnt_cmd == CMD_ACT);
    assign gnt_wr     = (gnt_cmd == CMD_WR);
    assign gnt_col    = (gnt_cmd == CMD_RD) || gnt_wr;

    assign bus.ref_gnt_o = (gnt_cmd == CMD_REF) ? gnt_onehot : '0;
    assign bus.pre_gnt_o = (gnt_cmd == CMD_PRE) ? gnt_onehot : '0;
    assign bus.act_gnt_o = gnt_act               ? gnt_onehot : '0;
    assign bus.rd_gnt_o  = (gnt_cmd == CMD_RD)  ? gnt_onehot : '0;
    assign bus.wr_gnt_o  = gnt_wr                ? gnt_onehot : '0;

    // Address of the winner: row for ACT, column for RD/WR, zero otherwise.
    always_comb begin
        addr_d = '0;
        case (gnt_cmd)
            CMD_ACT:        addr_d = AW'(bus.ra_i[int'(gnt_bank)*RA_WIDTH +: RA_WIDTH]);
            CMD_RD, CMD_WR: addr_d = AW'(bus.ca_i[int'(gnt_bank)*CA_WIDTH +: CA_WIDTH]);
            default:        addr_d = '0;
        endcase
    end

    // Round-robin pointer moves past the granted bank; no grant leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= (gnt_bank == BW'(NUM_BANKS - 1)) ? '0 : gnt_bank + BW'(1);
        end
    end

    // Inter-bank timing counters: a load beats the saturating decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrd_cnt <= '0;
            ccd_cnt <= '0;
            wtr_cnt <= '0;
        end else begin
            if (gnt_act)              rrd_cnt <= bus.t_rrd_m1;
            else if (rrd_cnt != '0)   rrd_cnt <= rrd_cnt - TW'(1);

            if (gnt_col)              ccd_cnt <= bus.t_ccd_m1;
            else if (ccd_cnt != '0)   ccd_cnt <= ccd_cnt - TW'(1);

            if (gnt_wr)               wtr_cnt <= bus.t_wtr_m1;
            else if (wtr_cnt != '0)   wtr_cnt <= wtr_cnt - TW'(1);
        end
    end

`ifdef SAL_SCHED_FAW_EN
    logic [TW-1:0] faw_cnt [4];
    logic [1:0]    faw_slot;

    // A free window slot (lowest index) exists while any slot counter is idle.
    always_comb begin
        faw_ok   = 1'b0;
        faw_slot = '0;
        for (int j = 3; j >= 0; j--) begin
            if (faw_cnt[j] == '0) begin
                faw_ok   = 1'b1;
                faw_slot = 2'(j);
            end
        end
    end

    // Each ACT claims one idle slot for t_faw_m1 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 4; j++) faw_cnt[j] <= '0;
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (gnt_act && faw_slot == 2'(j)) faw_cnt[j] <= bus.t_faw_m1;
                else if (faw_cnt[j] != '0)        faw_cnt[j] <= faw_cnt[j] - TW'(1);
            end
        end
    end
`else
    logic unused_faw;
    assign faw_ok     = 1'b1;
    assign unused_faw = ^bus.t_faw_m1;
`endif

    // Command register toward the PHY; idle cycles register a NOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            bank_q      <= '0;
            addr_q      <= '0;
        end else begin
            cmd_valid_q <= gnt_any;
            cmd_q       <= gnt_cmd;
            bank_q      <= gnt_any ? gnt_bank : '0;
            addr_q      <= addr_d;
        end
    end

    assign bus.cmd_valid_o = cmd_valid_q;
    assign bus.cmd_o       = cmd_q;
    assign bus.bank_o      = bank_q;
    assign bus.addr_o      = addr_q;

endmodule
